// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register of a classic five-stage in-order pipeline. It
// captures the decoded instruction leaving ID, resolves the destination
// register, computes operand forwarding selects for the instruction as it
// enters EX, and detects the load-use hazard that forces a one-cycle bubble.
//
// Ports
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   stall              freeze: every register holds its value
//   flush              squash: load a bubble regardless of stall
//   id_valid           ID holds a real instruction
//   id_rs/rt/rd        source and destination specifiers
//   id_rs_data/rt_data register-file read data
//   id_imm             sign-extended immediate
//   id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_reg_dst, id_alu_op
//                      decoded controls
//   mem_reg_write, mem_rd
//                      write enable and destination of the instruction in MEM
//   ex_*               registered EX controls, operands and resolved dest
//   fwd_a_sel/b_sel    registered operand selects:
//                      0 = register file, 1 = EX/MEM result, 2 = MEM/WB result
//   load_use_hazard    combinational; upstream holds PC and IF/ID when high
//
// Valid semantics: ex_valid marks a real instruction in EX. A bubble is an
// all-zero register image (ex_valid = 0, controls, dest, data, selects = 0),
// so downstream stages never need to qualify controls with ex_valid.
//
// Update priority per edge: rst > flush > stall > load-use bubble > capture.
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [RADDR_W-1:0] id_rs,
  input  logic [RADDR_W-1:0] id_rt,
  input  logic [RADDR_W-1:0] id_rd,
  input  logic [DATA_W-1:0]  id_rs_data,
  input  logic [DATA_W-1:0]  id_rt_data,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_alu_src,
  input  logic               id_reg_dst,
  input  logic [3:0]         id_alu_op,
  input  logic               mem_reg_write,
  input  logic [RADDR_W-1:0] mem_rd,
  output logic               ex_valid,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_alu_src,
  output logic [3:0]         ex_alu_op,
  output logic [RADDR_W-1:0] ex_dest,
  output logic [DATA_W-1:0]  ex_rs_data,
  output logic [DATA_W-1:0]  ex_rt_data,
  output logic [DATA_W-1:0]  ex_imm,
  output logic [1:0]         fwd_a_sel,
  output logic [1:0]         fwd_b_sel,
  output logic               load_use_hazard
);

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;

  // Pipeline registers
  logic               ex_valid_q,     ex_valid_d;
  logic               ex_reg_write_q, ex_reg_write_d;
  logic               ex_mem_read_q,  ex_mem_read_d;
  logic               ex_mem_write_q, ex_mem_write_d;
  logic               ex_alu_src_q,   ex_alu_src_d;
  logic [3:0]         ex_alu_op_q,    ex_alu_op_d;
  logic [RADDR_W-1:0] ex_dest_q,      ex_dest_d;
  logic [DATA_W-1:0]  ex_rs_data_q,   ex_rs_data_d;
  logic [DATA_W-1:0]  ex_rt_data_q,   ex_rt_data_d;
  logic [DATA_W-1:0]  ex_imm_q,       ex_imm_d;
  logic [1:0]         fwd_a_sel_q,    fwd_a_sel_d;
  logic [1:0]         fwd_b_sel_q,    fwd_b_sel_d;

  // Producer qualifiers. Register 0 is hard-wired, so a write to it never
  // produces a value worth forwarding.
  logic ex_produces;
  logic mem_produces;
  logic hazard;

  // Forwarding selects for the instruction being captured. The instruction
  // currently in EX will be in MEM next cycle, so a match against it selects
  // the EX/MEM result; the instruction in MEM now selects MEM/WB. The EX
  // match is tested first because it is the younger, more recent producer.
  logic [1:0] fwd_a_next;
  logic [1:0] fwd_b_next;

  always_comb begin
    ex_produces  = ex_valid_q && ex_reg_write_q && (ex_dest_q != '0);
    mem_produces = mem_reg_write && (mem_rd != '0);

    fwd_a_next = FWD_RF;
    if (ex_produces && (ex_dest_q == id_rs)) begin
      fwd_a_next = FWD_EX;
    end else if (mem_produces && (mem_rd == id_rs)) begin
      fwd_a_next = FWD_MEM;
    end

    fwd_b_next = FWD_RF;
    if (ex_produces && (ex_dest_q == id_rt)) begin
      fwd_b_next = FWD_EX;
    end else if (mem_produces && (mem_rd == id_rt)) begin
      fwd_b_next = FWD_MEM;
    end
  end

  // A load in EX cannot forward its data until it reaches MEM/WB, so a
  // dependent instruction in ID must wait one cycle. Gated by stall and
  // flush: while frozen or squashed no bubble insertion is requested.
  always_comb begin
    hazard = 1'b0;
    if (!stall && !flush && id_valid && ex_valid_q && ex_mem_read_q &&
        (ex_dest_q != '0) && ((ex_dest_q == id_rs) || (ex_dest_q == id_rt))) begin
      hazard = 1'b1;
    end
  end

  assign load_use_hazard = hazard;

  // Next-state selection
  always_comb begin
    // Default: hold (covers stall)
    ex_valid_d     = ex_valid_q;
    ex_reg_write_d = ex_reg_write_q;
    ex_mem_read_d  = ex_mem_read_q;
    ex_mem_write_d = ex_mem_write_q;
    ex_alu_src_d   = ex_alu_src_q;
    ex_alu_op_d    = ex_alu_op_q;
    ex_dest_d      = ex_dest_q;
    ex_rs_data_d   = ex_rs_data_q;
    ex_rt_data_d   = ex_rt_data_q;
    ex_imm_d       = ex_imm_q;
    fwd_a_sel_d    = fwd_a_sel_q;
    fwd_b_sel_d    = fwd_b_sel_q;

    if (flush || (!stall && hazard)) begin
      // Bubble: all-zero image
      ex_valid_d     = 1'b0;
      ex_reg_write_d = 1'b0;
      ex_mem_read_d  = 1'b0;
      ex_mem_write_d = 1'b0;
      ex_alu_src_d   = 1'b0;
      ex_alu_op_d    = 4'd0;
      ex_dest_d      = '0;
      ex_rs_data_d   = '0;
      ex_rt_data_d   = '0;
      ex_imm_d       = '0;
      fwd_a_sel_d    = FWD_RF;
      fwd_b_sel_d    = FWD_RF;
    end else if (!stall) begin
      // Normal capture
      ex_valid_d     = id_valid;
      ex_reg_write_d = id_reg_write;
      ex_mem_read_d  = id_mem_read;
      ex_mem_write_d = id_mem_write;
      ex_alu_src_d   = id_alu_src;
      ex_alu_op_d    = id_alu_op;
      ex_dest_d      = id_reg_dst ? id_rd : id_rt;
      ex_rs_data_d   = id_rs_data;
      ex_rt_data_d   = id_rt_data;
      ex_imm_d       = id_imm;
      fwd_a_sel_d    = fwd_a_next;
      fwd_b_sel_d    = fwd_b_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q     <= 1'b0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_mem_write_q <= 1'b0;
      ex_alu_src_q   <= 1'b0;
      ex_alu_op_q    <= 4'd0;
      ex_dest_q      <= '0;
      ex_rs_data_q   <= '0;
      ex_rt_data_q   <= '0;
      ex_imm_q       <= '0;
      fwd_a_sel_q    <= FWD_RF;
      fwd_b_sel_q    <= FWD_RF;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_mem_read_q  <= ex_mem_read_d;
      ex_mem_write_q <= ex_mem_write_d;
      ex_alu_src_q   <= ex_alu_src_d;
      ex_alu_op_q    <= ex_alu_op_d;
      ex_dest_q      <= ex_dest_d;
      ex_rs_data_q   <= ex_rs_data_d;
      ex_rt_data_q   <= ex_rt_data_d;
      ex_imm_q       <= ex_imm_d;
      fwd_a_sel_q    <= fwd_a_sel_d;
      fwd_b_sel_q    <= fwd_b_sel_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_reg_write = ex_reg_write_q;
  assign ex_mem_read  = ex_mem_read_q;
  assign ex_mem_write = ex_mem_write_q;
  assign ex_alu_src   = ex_alu_src_q;
  assign ex_alu_op    = ex_alu_op_q;
  assign ex_dest      = ex_dest_q;
  assign ex_rs_data   = ex_rs_data_q;
  assign ex_rt_data   = ex_rt_data_q;
  assign ex_imm       = ex_imm_q;
  assign fwd_a_sel    = fwd_a_sel_q;
  assign fwd_b_sel    = fwd_b_sel_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//
// Inputs change 2 time units after each rising edge; outputs are compared
// against the reference model on every falling edge. Directed scenarios pin
// forwarding, load-use, stall/flush and reset behaviour with literal values;
// a randomized phase then exercises the whole input space.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        stall = 0, flush = 0, id_valid = 0;
  logic [4:0]  id_rs = 0, id_rt = 0, id_rd = 0;
  logic [31:0] id_rs_data = 0, id_rt_data = 0, id_imm = 0;
  logic        id_reg_write = 0, id_mem_read = 0, id_mem_write = 0;
  logic        id_alu_src = 0, id_reg_dst = 0;
  logic [3:0]  id_alu_op = 0;
  logic        mem_reg_write = 0;
  logic [4:0]  mem_rd = 0;

  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src;
  logic [3:0]  ex_alu_op;
  logic [4:0]  ex_dest;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        load_use_hazard;

  id_ex_stage #(.DATA_W(32), .RADDR_W(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
    .id_reg_dst(id_reg_dst), .id_alu_op(id_alu_op),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .ex_dest(ex_dest),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .load_use_hazard(load_use_hazard)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // What EX should hold: the instruction last accepted, or an empty slot.
  typedef struct packed {
    logic        valid, rw, mr, mw, as;
    logic [3:0]  op;
    logic [4:0]  dest;
    logic [31:0] rsd, rtd, imm;
    logic [1:0]  fa, fb;
  } ex_t;

  ex_t m = '0;

  // Where should operand 'src' come from, given who is in EX and MEM now?
  function automatic logic [1:0] exp_fwd(input logic [4:0] src);
    if (src == 0) return 2'd0;
    if (m.valid && m.rw && m.dest == src) return 2'd1;
    if (mem_reg_write && mem_rd == src) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic exp_hazard();
    if (stall || flush || !id_valid) return 1'b0;
    return m.valid && m.mr && (m.dest != 0) && (m.dest == id_rs || m.dest == id_rt);
  endfunction

  always @(posedge clk or posedge rst) begin
    ex_t n;
    n = '0;
    if (rst || flush) begin
      m = '0;
    end else if (!stall) begin
      if (!exp_hazard()) begin
        n.valid = id_valid;
        n.rw    = id_reg_write;
        n.mr    = id_mem_read;
        n.mw    = id_mem_write;
        n.as    = id_alu_src;
        n.op    = id_alu_op;
        n.dest  = id_reg_dst ? id_rd : id_rt;
        n.rsd   = id_rs_data;
        n.rtd   = id_rt_data;
        n.imm   = id_imm;
        n.fa    = exp_fwd(id_rs);
        n.fb    = exp_fwd(id_rt);
      end
      m = n;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    check("ex_valid",     {31'd0, ex_valid},     {31'd0, m.valid});
    check("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, m.rw});
    check("ex_mem_read",  {31'd0, ex_mem_read},  {31'd0, m.mr});
    check("ex_mem_write", {31'd0, ex_mem_write}, {31'd0, m.mw});
    check("ex_alu_src",   {31'd0, ex_alu_src},   {31'd0, m.as});
    check("ex_alu_op",    {28'd0, ex_alu_op},    {28'd0, m.op});
    check("ex_dest",      {27'd0, ex_dest},      {27'd0, m.dest});
    check("ex_rs_data",   ex_rs_data,            m.rsd);
    check("ex_rt_data",   ex_rt_data,            m.rtd);
    check("ex_imm",       ex_imm,                m.imm);
    check("fwd_a_sel",    {30'd0, fwd_a_sel},    {30'd0, m.fa});
    check("fwd_b_sel",    {30'd0, fwd_b_sel},    {30'd0, m.fb});
    check("load_use",     {31'd0, load_use_hazard}, {31'd0, exp_hazard()});
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic present(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic dst);
    id_valid     = 1'b1;
    id_rs        = rs;
    id_rt        = rt;
    id_rd        = rd;
    id_reg_write = rw;
    id_mem_read  = mr;
    id_mem_write = 1'b0;
    id_alu_src   = 1'($urandom_range(0, 1));
    id_reg_dst   = dst;
    id_alu_op    = 4'($urandom_range(0, 15));
    id_rs_data   = $urandom;
    id_rt_data   = $urandom;
    id_imm       = $urandom;
  endtask

  task automatic set_mem(input logic w, input logic [4:0] rd);
    mem_reg_write = w;
    mem_rd        = rd;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    check("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("reset_fwd_a",    {30'd0, fwd_a_sel}, 32'd0);
    check("reset_rs_data",  ex_rs_data, 32'd0);

    // add $3 in EX; ID reads rs=3, rt=4
    set_mem(1'b0, 5'd0);
    present(5'd10, 5'd11, 5'd3, 1'b1, 1'b0, 1'b1);
    cyc();
    present(5'd3, 5'd4, 5'd9, 1'b0, 1'b0, 1'b1);
    cyc();
    check("add_fwd_a", {30'd0, fwd_a_sel}, 32'd1);
    check("add_fwd_b", {30'd0, fwd_b_sel}, 32'd0);

    // EX and MEM both write $5: EX wins; with EX not writing, MEM is used
    present(5'd12, 5'd13, 5'd5, 1'b1, 1'b0, 1'b1);
    cyc();
    present(5'd5, 5'd14, 5'd15, 1'b0, 1'b0, 1'b1);
    set_mem(1'b1, 5'd5);
    cyc();
    check("both_fwd_a", {30'd0, fwd_a_sel}, 32'd1);
    present(5'd12, 5'd13, 5'd5, 1'b0, 1'b0, 1'b1);
    set_mem(1'b0, 5'd0);
    cyc();
    present(5'd5, 5'd14, 5'd15, 1'b0, 1'b0, 1'b1);
    set_mem(1'b1, 5'd5);
    cyc();
    check("mem_fwd_a", {30'd0, fwd_a_sel}, 32'd2);

    // lw $7 in EX; dependent instruction reads rt=7
    set_mem(1'b0, 5'd0);
    present(5'd16, 5'd7, 5'd0, 1'b1, 1'b1, 1'b0);
    cyc();
    present(5'd1, 5'd7, 5'd12, 1'b1, 1'b0, 1'b1);
    #1 check("lu_hazard", {31'd0, load_use_hazard}, 32'd1);
    cyc();
    check("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    check("lu_bubble_rw",    {31'd0, ex_reg_write}, 32'd0);
    check("lu_bubble_dest",  {27'd0, ex_dest}, 32'd0);
    set_mem(1'b1, 5'd7);
    #1 check("lu_hazard_gone", {31'd0, load_use_hazard}, 32'd0);
    cyc();
    check("lu_replay_valid", {31'd0, ex_valid}, 32'd1);
    check("lu_replay_fwd_b", {30'd0, fwd_b_sel}, 32'd2);
    check("lu_replay_dest",  {27'd0, ex_dest}, 32'd12);

    // Writes to $0 never forward
    set_mem(1'b0, 5'd0);
    present(5'd2, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1);
    cyc();
    present(5'd0, 5'd6, 5'd8, 1'b0, 1'b0, 1'b1);
    set_mem(1'b1, 5'd0);
    cyc();
    check("r0_fwd_a", {30'd0, fwd_a_sel}, 32'd0);

    // Stall for 3 cycles with changing ID, then flush while stalled
    set_mem(1'b0, 5'd0);
    present(5'd20, 5'd21, 5'd22, 1'b1, 1'b0, 1'b1);
    id_rs_data = 32'h1234_5678;
    cyc();
    check("pre_stall_rs_data", ex_rs_data, 32'h1234_5678);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      present(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 31)), 1'b1, 1'b1, 1'b0);
      cyc();
      check("stall_rs_data", ex_rs_data, 32'h1234_5678);
      check("stall_dest", {27'd0, ex_dest}, 32'd22);
    end
    flush = 1'b1;
    cyc();
    check("flush_stall_valid", {31'd0, ex_valid}, 32'd0);
    check("flush_stall_rs",    ex_rs_data, 32'd0);
    stall = 1'b0;
    flush = 1'b0;

    // Reset pulsed between edges, with stall high, discards the instruction
    present(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1);
    id_imm = 32'hCAFE_F00D;
    cyc();
    check("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
    check("pre_rst_imm", ex_imm, 32'hCAFE_F00D);
    stall = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, ex_valid}, 32'd0);
    check("mid_rst_imm",   ex_imm, 32'd0);
    rst = 1'b0;
    stall = 1'b0;
    cyc();
    check("post_rst_valid", {31'd0, ex_valid}, 32'd1);
    check("post_rst_imm", ex_imm, 32'hCAFE_F00D);

    // Randomized phase: small register numbers so matches are frequent
    for (int i = 0; i < 600; i++) begin
      stall        = ($urandom_range(0, 9) == 0);
      flush        = ($urandom_range(0, 19) == 0);
      id_valid     = ($urandom_range(0, 3) != 0);
      id_rs        = 5'($urandom_range(0, 7));
      id_rt        = 5'($urandom_range(0, 7));
      id_rd        = 5'($urandom_range(0, 7));
      id_reg_write = 1'($urandom_range(0, 1));
      id_mem_read  = ($urandom_range(0, 2) == 0);
      id_mem_write = 1'($urandom_range(0, 1));
      id_alu_src   = 1'($urandom_range(0, 1));
      id_reg_dst   = 1'($urandom_range(0, 1));
      id_alu_op    = 4'($urandom_range(0, 15));
      id_rs_data   = $urandom;
      id_rt_data   = $urandom;
      id_imm       = $urandom;
      mem_reg_write = 1'($urandom_range(0, 1));
      mem_rd        = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
      cyc();
    end

    stall = 1'b0;
    flush = 1'b0;
    repeat (2) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, default 32, operand/immediate width.
REQ-002 Parameter RADDR_W, default 5, register-specifier width.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high. Ports: clk (in, 1, rising-edge) and rst (in, 1, async active-high).
REQ-004 stall  in  1  whole-pipeline freeze; hold all state.
REQ-005 flush  in  1  squash capture; load bubble.
REQ-006 id_valid  in  1  ID holds a real instruction.
REQ-007 id_rs, id_rt, id_rd  in  RADDR_W each  source and destination specifiers.
REQ-008 id_rs_data, id_rt_data, id_imm  in  DATA_W each  register-file reads, sign-extended immediate.
REQ-009 id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_reg_dst  in  1 each  decoded controls.
REQ-010 id_alu_op  in  4  ALU operation.
REQ-011 mem_reg_write  in  1; mem_rd  in  RADDR_W  register write and destination of the instruction now in MEM.
REQ-012 ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src  out  1 each  registered EX controls.
REQ-013 ex_alu_op  out  4; ex_dest  out  RADDR_W  resolved destination.
REQ-014 ex_rs_data, ex_rt_data, ex_imm  out  DATA_W  registered operands.
REQ-015 fwd_a_sel, fwd_b_sel  out  2  operand mux selects: 0 = register file, 1 = EX/MEM result, 2 = MEM/WB result.
REQ-016 load_use_hazard  out  1  combinational; upstream holds PC and IF/ID when high.

Function
REQ-017 All outputs except load_use_hazard SHALL be registers updated only on rising clk.
REQ-018 Update priority SHALL be: rst > flush > stall > load-use bubble > normal capture.
REQ-019 Normal capture SHALL load all id_* fields with one-cycle latency; ex_valid = id_valid.
REQ-020 ex_dest SHALL capture id_rd when id_reg_dst = 1, else id_rt.
REQ-021 fwd_a_sel SHALL capture 1 if ex_valid, ex_reg_write, ex_dest != 0 and ex_dest == id_rs (current register values); else 2 if mem_reg_write, mem_rd != 0 and mem_rd == id_rs; else 0.
REQ-022 fwd_b_sel SHALL use the same rule against id_rt.
REQ-023 When both EX and MEM match, the EX match (1) SHALL win.
REQ-024 Register 0 SHALL never forward; sel value 3 SHALL never be produced.
REQ-025 load_use_hazard SHALL be 1 iff id_valid, ex_valid, ex_mem_read, ex_dest != 0 and ex_dest equals id_rs or id_rt; it SHALL be forced to 0 while stall or flush is high.
REQ-026 A bubble (flush, or load_use_hazard with stall low) SHALL set ex_valid, all ex controls, ex_alu_op, ex_dest and both sels to 0 and set ex data fields to 0.
REQ-027 On the cycle after a load-use bubble, the re-presented instruction SHALL capture with sel 2 for the load's destination.
REQ-028 stall high SHALL hold every register unchanged, including across multiple cycles.
REQ-029 Same-cycle WB write and ID read SHALL be resolved by the register file; this block SHALL NOT forward from WB.

Reset
REQ-030 rst high SHALL immediately clear every registered output to 0, regardless of clk, stall or flush.
REQ-031 Reset mid-operation SHALL discard the captured instruction; the first edge after release performs a normal capture.

Verification
REQ-032 add $3 in EX (reg_write, dest 3), ID reads rs=3, rt=4 -> next cycle fwd_a_sel=1, fwd_b_sel=0.
REQ-033 ex_dest=5 and mem_rd=5 both writing, ID rs=5 -> fwd_a_sel=1; with EX reg_write=0 -> fwd_a_sel=2.
REQ-034 lw $7 in EX, ID rt=7 -> load_use_hazard=1, next cycle ex_valid=0 and controls 0; re-presented instruction next edge -> fwd_b_sel=2.
REQ-035 ID writes to $0, following instruction reads rs=0 -> fwd_a_sel=0.
REQ-036 stall held 3 cycles with changing id_* -> outputs unchanged; flush with stall=1 -> bubble.
REQ-037 rst pulsed between edges with ex_valid=1 -> all outputs 0 before next edge.
